// File: rtl/trax_move_decoder.sv
// Receive-side ASCII parser for the Trax UART link: turns the color line and
// move lines ("<letters><digits><type>\n") into the 22-bit move word.
module trax_move_decoder #(
    parameter int MAX_COL_LETTERS = 2,
    parameter int MAX_ROW_DIGITS  = 3,
    parameter int EXPECT_COLOR    = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [21:0] move_out,
    output logic        move_valid,
    output logic        color,
    output logic        color_valid,
    output logic        parse_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_COLOR,
        S_COLEOL,
        S_COL0,
        S_COL,
        S_ROW,
        S_EOL,
        S_ERR
    } state_t;

    localparam logic [1:0] MAX_LETTERS = 2'(MAX_COL_LETTERS);
    localparam logic [1:0] MAX_DIGITS  = 2'(MAX_ROW_DIGITS);

    state_t      state_q, state_d;
    logic [9:0]  col_acc_q, col_acc_d;
    logic [9:0]  row_acc_q, row_acc_d;
    logic [1:0]  letter_cnt_q, letter_cnt_d;
    logic [1:0]  digit_cnt_q, digit_cnt_d;
    logic [1:0]  type_q, type_d;
    logic        pend_color_q, pend_color_d;
    logic [21:0] move_q, move_d;
    logic        move_valid_q, move_valid_d;
    logic        color_q, color_d;
    logic        color_valid_q, color_valid_d;
    logic        parse_error_q, parse_error_d;

    logic        is_letter, is_digit, is_type, is_eol, is_cr, err;
    logic [4:0]  letter_val;
    logic [3:0]  digit_val;
    logic [1:0]  type_val;
    logic [9:0]  col_mul, row_mul;
    state_t      recover_state;

    // Byte classification: '@'..'Z' and '0'..'9' map to their values via the low bits.
    always_comb begin
        is_letter  = (rx_data >= 8'd64) && (rx_data <= 8'd90);
        is_digit   = (rx_data >= 8'd48) && (rx_data <= 8'd57);
        is_type    = (rx_data == 8'd43) || (rx_data == 8'd92) || (rx_data == 8'd47);
        is_eol     = (rx_data == 8'd10);
        is_cr      = (rx_data == 8'd13);
        letter_val = rx_data[4:0];
        digit_val  = rx_data[3:0];
        type_val   = (rx_data == 8'd92) ? 2'b01 : (rx_data == 8'd47) ? 2'b10 : 2'b00;
        col_mul    = col_acc_q * 10'd26;
        row_mul    = row_acc_q * 10'd10;
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        col_acc_d     = col_acc_q;
        row_acc_d     = row_acc_q;
        letter_cnt_d  = letter_cnt_q;
        digit_cnt_d   = digit_cnt_q;
        type_d        = type_q;
        pend_color_d  = pend_color_q;
        move_d        = move_q;
        move_valid_d  = 1'b0;
        color_d       = color_q;
        color_valid_d = color_valid_q;
        parse_error_d = 1'b0;
        err           = 1'b0;

        if ((EXPECT_COLOR != 0) && !color_valid_q) recover_state = S_COLOR;
        else                                        recover_state = S_COL0;

        if (rx_valid && !is_cr) begin
            case (state_q)
                S_COLOR: begin
                    if (rx_data == 8'd87 || rx_data == 8'd66) begin
                        pend_color_d = (rx_data == 8'd66);
                        state_d      = S_COLEOL;
                    end else err = 1'b1;
                end
                S_COLEOL: begin
                    if (is_eol) begin
                        color_d       = pend_color_q;
                        color_valid_d = 1'b1;
                        state_d       = S_COL0;
                    end else err = 1'b1;
                end
                S_COL0: begin
                    if (is_letter) begin
                        col_acc_d    = {5'd0, letter_val};
                        letter_cnt_d = 2'd1;
                        state_d      = S_COL;
                    end else if (!is_eol) err = 1'b1;
                end
                S_COL: begin
                    // A zero accumulator here means the first letter was '@', which ends the column.
                    if (is_letter && (letter_cnt_q < MAX_LETTERS) && (col_acc_q != 10'd0)
                        && (letter_val != 5'd0)) begin
                        col_acc_d    = col_mul + {5'd0, letter_val};
                        letter_cnt_d = letter_cnt_q + 2'd1;
                    end else if (is_digit) begin
                        row_acc_d   = {6'd0, digit_val};
                        digit_cnt_d = 2'd1;
                        state_d     = S_ROW;
                    end else err = 1'b1;
                end
                S_ROW: begin
                    if (is_digit && (digit_cnt_q < MAX_DIGITS)) begin
                        row_acc_d   = row_mul + {6'd0, digit_val};
                        digit_cnt_d = digit_cnt_q + 2'd1;
                    end else if (is_type) begin
                        type_d  = type_val;
                        state_d = S_EOL;
                    end else err = 1'b1;
                end
                S_EOL: begin
                    if (is_eol) begin
                        move_d       = {type_q, col_acc_q, row_acc_q};
                        move_valid_d = 1'b1;
                        state_d      = S_COL0;
                    end else err = 1'b1;
                end
                S_ERR: begin
                    if (is_eol) state_d = recover_state;
                end
                default: state_d = recover_state;
            endcase

            if (err) begin
                parse_error_d = 1'b1;
                state_d       = is_eol ? recover_state : S_ERR;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if (EXPECT_COLOR != 0) state_q <= S_COLOR;
            else                   state_q <= S_COL0;
            col_acc_q     <= '0;
            row_acc_q     <= '0;
            letter_cnt_q  <= '0;
            digit_cnt_q   <= '0;
            type_q        <= '0;
            pend_color_q  <= 1'b0;
            move_q        <= '0;
            move_valid_q  <= 1'b0;
            color_q       <= 1'b0;
            color_valid_q <= 1'b0;
            parse_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_acc_q     <= col_acc_d;
            row_acc_q     <= row_acc_d;
            letter_cnt_q  <= letter_cnt_d;
            digit_cnt_q   <= digit_cnt_d;
            type_q        <= type_d;
            pend_color_q  <= pend_color_d;
            move_q        <= move_d;
            move_valid_q  <= move_valid_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            parse_error_q <= parse_error_d;
        end
    end

    assign move_out    = move_q;
    assign move_valid  = move_valid_q;
    assign color       = color_q;
    assign color_valid = color_valid_q;
    assign parse_error = parse_error_q;
    assign busy        = (state_q != S_COLOR) && (state_q != S_COL0);

endmodule

// File: tb/tb_trax_move_decoder.sv
// Directed bench for trax_move_decoder: feeds ASCII lines byte-by-byte and
// checks decoded moves, color, error pulses and their exact timing.
module tb_trax_move_decoder;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [21:0] move_out;
    logic        move_valid;
    logic        color;
    logic        color_valid;
    logic        parse_error;
    logic        busy;

    int total = 0;
    int bad   = 0;

    trax_move_decoder #(
        .MAX_COL_LETTERS(2),
        .MAX_ROW_DIGITS (3),
        .EXPECT_COLOR   (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .move_out   (move_out),
        .move_valid (move_valid),
        .color      (color),
        .color_valid(color_valid),
        .parse_error(parse_error),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [21:0] mk(input logic [1:0] t, input int c, input int r);
        return {t, 10'(c), 10'(r)};
    endfunction

    // Sends one line back-to-back, then one idle cycle; records where pulses appeared.
    task automatic send_line(input string s, output int mv_idx, output int mv_n,
                             output int err_idx, output int err_n);
        mv_idx = -1; mv_n = 0; err_idx = -1; err_n = 0;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clock);
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(posedge clock);
            #1;
            if (move_valid) begin
                mv_n++;
                if (mv_idx < 0) mv_idx = i;
            end
            if (parse_error) begin
                err_n++;
                if (err_idx < 0) err_idx = i;
            end
        end
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        @(posedge clock);
        #1;
        if (move_valid) mv_n++;
        if (parse_error) err_n++;
    endtask

    task automatic do_line(input string tag, input string s, input int exp_mv_idx,
                           input int exp_err_idx, input logic [21:0] exp_move);
        int mv_idx, mv_n, err_idx, err_n;
        send_line(s, mv_idx, mv_n, err_idx, err_n);
        check({tag, ":mv_idx"},  mv_idx,  exp_mv_idx);
        check({tag, ":mv_n"},    mv_n,    (exp_mv_idx >= 0) ? 1 : 0);
        check({tag, ":err_idx"}, err_idx, exp_err_idx);
        check({tag, ":err_n"},   err_n,   (exp_err_idx >= 0) ? 1 : 0);
        check({tag, ":move"},    move_out, exp_move);
        check({tag, ":busy"},    busy,    0);
    endtask

    initial begin
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        #23;
        check("rst:move_out",    move_out,    0);
        check("rst:move_valid",  move_valid,  0);
        check("rst:color",       color,       0);
        check("rst:color_valid", color_valid, 0);
        check("rst:parse_error", parse_error, 0);
        check("rst:busy",        busy,        0);
        @(negedge clock);
        reset = 1'b1;

        do_line("colorB", "B\n", -1, -1, 22'd0);
        check("colorB:color",       color,       1);
        check("colorB:color_valid", color_valid, 1);

        do_line("A1+",    "A1+\n",             3, -1, mk(2'b00, 1, 1));
        do_line("ZZ999/", "ZZ999/\n",          6, -1, mk(2'b10, 702, 999));
        do_line("@0bs",   "@0\\\n",            3, -1, mk(2'b01, 0, 0));
        do_line("AB12cr", "AB12\015+\015\n",   7, -1, mk(2'b00, 28, 12));
        do_line("ABC1+",  "ABC1+\n",          -1,  2, mk(2'b00, 28, 12));
        do_line("C3/",    "C3/\n",             3, -1, mk(2'b10, 3, 3));
        do_line("A1234+", "A1234+\n",         -1,  4, mk(2'b10, 3, 3));
        do_line("A12eol", "A12\n",            -1,  3, mk(2'b10, 3, 3));
        do_line("D5+",    "D5+\n",             3, -1, mk(2'b00, 4, 5));
        do_line("@A1+",   "@A1+\n",           -1,  1, mk(2'b00, 4, 5));
        do_line("recolor","W\n",              -1,  1, mk(2'b00, 4, 5));
        do_line("blank",  "\n",               -1, -1, mk(2'b00, 4, 5));
        check("locked:color",       color,       1);
        check("locked:color_valid", color_valid, 1);

        // Abort "AB1" mid-line with back-to-back bytes, then reset.
        begin
            string s = "AB1";
            for (int i = 0; i < s.len(); i++) begin
                @(negedge clock);
                rx_data  = s[i];
                rx_valid = 1'b1;
            end
            @(posedge clock);
            #1;
            check("midline:busy", busy, 1);
            @(negedge clock);
            rx_valid = 1'b0;
            reset    = 1'b0;
            #1;
            check("midrst:move_out",    move_out,    0);
            check("midrst:move_valid",  move_valid,  0);
            check("midrst:color",       color,       0);
            check("midrst:color_valid", color_valid, 0);
            check("midrst:parse_error", parse_error, 0);
            check("midrst:busy",        busy,        0);
            @(negedge clock);
            reset = 1'b1;
        end

        do_line("colorW", "W\n", -1, -1, 22'd0);
        check("colorW:color",       color,       0);
        check("colorW:color_valid", color_valid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
